// File: rtl/secuenciador_barrido_rtc.sv
// -----------------------------------------------------------------------------
// secuenciador_barrido_rtc
//
// Hardware master for the RTC port interface. It replaces the PicoBlaze for
// routine traffic: it sweeps the time/date registers of the multiplexed-bus
// RTC into a shadow bank, commits that bank atomically so readers never see a
// torn time, and executes single register writes on request.
//
// Ports:
//   clk, reset              system clock, asynchronous active-high reset
//   iniciar                 one-cycle request for an immediate sweep
//   escribir                one-cycle request for a single register write
//   addr_esc, dato_esc      RTC address / data for that write
//   port_id, out_port       port select and data towards the RTC interface
//   write_strobe            one-cycle port write strobe
//   read_strobe             unused by this master, always 0
//   dato_rtc                read data from the RTC interface
//   fin_lectura_escritura   transaction-done flag from the RTC interface
//   segundos..anio          committed register bank
//   actualizado             one-cycle pulse, coincident with new bank values
//   ocupado                 high whenever the sequencer is not idle
//   error_timeout           one-cycle pulse when the RTC fails to respond
// -----------------------------------------------------------------------------
module secuenciador_barrido_rtc #(
  parameter logic [7:0]  ADDR_BASE      = 8'h21,
  parameter int          N_REGS         = 6,
  parameter logic [23:0] PERIODO_CICLOS = 24'd10_000_000,
  parameter logic [9:0]  TIMEOUT_CICLOS = 10'd1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       escribir,
  input  logic [7:0] addr_esc,
  input  logic [7:0] dato_esc,
  output logic [7:0] port_id,
  output logic [7:0] out_port,
  output logic       write_strobe,
  output logic       read_strobe,
  input  logic [7:0] dato_rtc,
  input  logic       fin_lectura_escritura,
  output logic [7:0] segundos,
  output logic [7:0] minutos,
  output logic [7:0] horas,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] anio,
  output logic       actualizado,
  output logic       ocupado,
  output logic       error_timeout
);

  localparam logic [7:0] PUERTO_DIR  = 8'h00;
  localparam logic [7:0] PUERTO_DATO = 8'h01;
  localparam logic [7:0] PUERTO_CMD  = 8'h0E;
  localparam logic [7:0] PUERTO_NULO = 8'hFF;

  typedef enum logic [3:0] {
    REPOSO,
    DIR,
    DATO,
    INICIO,
    ESPERA_FIN,
    CAPTURA,
    ESPERA_BAJA,
    SIGUIENTE,
    COMMIT
  } estado_t;

  estado_t     state_reg, state_next;
  logic        modo_lectura_reg, modo_lectura_next;
  logic [2:0]  index_reg, index_next;
  logic [7:0]  addr_reg, addr_next;
  logic [7:0]  dato_reg, dato_next;
  logic [9:0]  timeout_reg, timeout_next;
  logic        actualizado_reg;
  logic        error_timeout_reg;
  logic        pending_reg;

  logic        captura_en;
  logic        commit_en;
  logic        error_next;
  logic        arrancar;
  logic        tick;
  logic        limite;
  logic [47:0] banco_bus;

  // The wait has expired when the counter is about to reach TIMEOUT_CICLOS.
  // This places the error pulse exactly TIMEOUT_CICLOS+1 cycles after the
  // start strobe. Extended by one bit so the +1 cannot wrap.
  assign limite = ({1'b0, timeout_reg} + 11'd1) >= {1'b0, TIMEOUT_CICLOS};

  // ---------------------------------------------------------------------------
  // State and control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg         <= REPOSO;
      modo_lectura_reg  <= 1'b0;
      index_reg         <= 3'd0;
      addr_reg          <= 8'h00;
      dato_reg          <= 8'h00;
      timeout_reg       <= 10'd0;
      actualizado_reg   <= 1'b0;
      error_timeout_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      modo_lectura_reg  <= modo_lectura_next;
      index_reg         <= index_next;
      addr_reg          <= addr_next;
      dato_reg          <= dato_next;
      timeout_reg       <= timeout_next;
      // Registered so the pulse lands in the same cycle as the new bank.
      actualizado_reg   <= commit_en;
      error_timeout_reg <= error_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic and port drive. Strobes are Moore outputs of the DIR,
  // DATO and INICIO states, so they last exactly one cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next        = state_reg;
    modo_lectura_next = modo_lectura_reg;
    index_next        = index_reg;
    addr_next         = addr_reg;
    dato_next         = dato_reg;
    timeout_next      = timeout_reg;
    port_id           = PUERTO_NULO;
    out_port          = 8'h00;
    write_strobe      = 1'b0;
    captura_en        = 1'b0;
    commit_en         = 1'b0;
    error_next        = 1'b0;
    arrancar          = 1'b0;

    unique case (state_reg)
      REPOSO: begin
        // A write wins over any sweep request; a pending sweep is kept for later.
        if (escribir) begin
          addr_next         = addr_esc;
          dato_next         = dato_esc;
          modo_lectura_next = 1'b0;
          state_next        = DIR;
        end else if (iniciar || pending_reg) begin
          modo_lectura_next = 1'b1;
          index_next        = 3'd0;
          arrancar          = 1'b1;
          state_next        = DIR;
        end
      end

      DIR: begin
        write_strobe = 1'b1;
        port_id      = PUERTO_DIR;
        out_port     = modo_lectura_reg ? (ADDR_BASE + {5'd0, index_reg}) : addr_reg;
        state_next   = modo_lectura_reg ? INICIO : DATO;
      end

      DATO: begin
        write_strobe = 1'b1;
        port_id      = PUERTO_DATO;
        out_port     = dato_reg;
        state_next   = INICIO;
      end

      INICIO: begin
        write_strobe = 1'b1;
        port_id      = PUERTO_CMD;
        out_port     = {7'd0, modo_lectura_reg};
        timeout_next = 10'd0;
        state_next   = ESPERA_FIN;
      end

      ESPERA_FIN: begin
        if (fin_lectura_escritura) begin
          state_next = CAPTURA;
        end else if (limite) begin
          error_next = 1'b1;
          state_next = REPOSO;
        end else begin
          timeout_next = timeout_reg + 10'd1;
        end
      end

      CAPTURA: begin
        // fin is still high here, so dato_rtc is valid this cycle.
        captura_en   = modo_lectura_reg;
        timeout_next = 10'd0;
        state_next   = ESPERA_BAJA;
      end

      ESPERA_BAJA: begin
        if (!fin_lectura_escritura) begin
          state_next = modo_lectura_reg ? SIGUIENTE : REPOSO;
        end else if (limite) begin
          error_next = 1'b1;
          state_next = REPOSO;
        end else begin
          timeout_next = timeout_reg + 10'd1;
        end
      end

      SIGUIENTE: begin
        if (index_reg == 3'(N_REGS - 1)) begin
          state_next = COMMIT;
        end else begin
          index_next = index_reg + 3'd1;
          state_next = DIR;
        end
      end

      COMMIT: begin
        commit_en  = 1'b1;
        state_next = REPOSO;
      end

      default: begin
        state_next = REPOSO;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Auto-sweep period counter. Requests collapse into a single pending flag;
  // a new period ending in the same cycle a sweep starts re-arms the flag.
  // ---------------------------------------------------------------------------
  generate
    if (PERIODO_CICLOS != 24'd0) begin : g_periodo
      logic [23:0] periodo_reg;

      assign tick = (periodo_reg == PERIODO_CICLOS - 24'd1);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          periodo_reg <= 24'd0;
        end else if (tick) begin
          periodo_reg <= 24'd0;
        end else begin
          periodo_reg <= periodo_reg + 24'd1;
        end
      end
    end else begin : g_sin_periodo
      assign tick = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_reg <= 1'b0;
    end else if (tick) begin
      pending_reg <= 1'b1;
    end else if (arrancar) begin
      pending_reg <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow and committed banks. Aborted sweeps only ever touch the shadow, so
  // the committed bank changes solely on COMMIT.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_banco
      logic [7:0] shadow_reg;
      logic [7:0] bank_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          shadow_reg <= 8'h00;
          bank_reg   <= 8'h00;
        end else begin
          if (captura_en && (index_reg == 3'(gi))) begin
            shadow_reg <= dato_rtc;
          end
          if (commit_en) begin
            bank_reg <= shadow_reg;
          end
        end
      end

      assign banco_bus[gi*8 +: 8] = bank_reg;
    end
  endgenerate

  assign segundos      = banco_bus[7:0];
  assign minutos       = banco_bus[15:8];
  assign horas         = banco_bus[23:16];
  assign dia           = banco_bus[31:24];
  assign mes           = banco_bus[39:32];
  assign anio          = banco_bus[47:40];
  assign actualizado   = actualizado_reg;
  assign error_timeout = error_timeout_reg;
  assign ocupado       = (state_reg != REPOSO);
  assign read_strobe   = 1'b0;

endmodule

// File: tb/tb_secuenciador_barrido_rtc.sv
// -----------------------------------------------------------------------------
// Testbench for secuenciador_barrido_rtc.
// Instance 0: auto-sweep disabled, exercised by directed requests and checked
// by a scoreboard (expected strobes/commits/timeouts queued by the stimulus,
// popped by a negedge monitor). Instance 1: 200-cycle auto-sweep period with a
// slow-then-fast RTC model to exercise collapsing of pending sweeps.
// -----------------------------------------------------------------------------
module tb_secuenciador_barrido_rtc;

  logic       clk = 1'b0;
  logic       reset;
  logic       iniciar;
  logic       escribir;
  logic [7:0] addr_esc;
  logic [7:0] dato_esc;

  logic [7:0] pid  [2];
  logic [7:0] opt  [2];
  logic [7:0] drtc [2];
  logic       wstb [2];
  logic       rstb [2];
  logic       fin  [2];
  logic       act  [2];
  logic       ocu  [2];
  logic       err  [2];
  logic [7:0] bk   [2][6];

  logic       mudo    [2];
  int         retardo [2];

  int checks = 0;
  int errors = 0;
  int ciclo = 0;
  int ultimo_0e = 0;

  always #5 clk = ~clk;
  always @(posedge clk) ciclo <= ciclo + 1;

  secuenciador_barrido_rtc #(
    .ADDR_BASE(8'h21), .N_REGS(6), .PERIODO_CICLOS(24'd0), .TIMEOUT_CICLOS(10'd1023)
  ) dut (
    .clk(clk), .reset(reset), .iniciar(iniciar), .escribir(escribir),
    .addr_esc(addr_esc), .dato_esc(dato_esc),
    .port_id(pid[0]), .out_port(opt[0]), .write_strobe(wstb[0]), .read_strobe(rstb[0]),
    .dato_rtc(drtc[0]), .fin_lectura_escritura(fin[0]),
    .segundos(bk[0][0]), .minutos(bk[0][1]), .horas(bk[0][2]),
    .dia(bk[0][3]), .mes(bk[0][4]), .anio(bk[0][5]),
    .actualizado(act[0]), .ocupado(ocu[0]), .error_timeout(err[0])
  );

  secuenciador_barrido_rtc #(
    .ADDR_BASE(8'h21), .N_REGS(6), .PERIODO_CICLOS(24'd200), .TIMEOUT_CICLOS(10'd1023)
  ) dut_p (
    .clk(clk), .reset(reset), .iniciar(1'b0), .escribir(1'b0),
    .addr_esc(8'h00), .dato_esc(8'h00),
    .port_id(pid[1]), .out_port(opt[1]), .write_strobe(wstb[1]), .read_strobe(rstb[1]),
    .dato_rtc(drtc[1]), .fin_lectura_escritura(fin[1]),
    .segundos(bk[1][0]), .minutos(bk[1][1]), .horas(bk[1][2]),
    .dia(bk[1][3]), .mes(bk[1][4]), .anio(bk[1][5]),
    .actualizado(act[1]), .ocupado(ocu[1]), .error_timeout(err[1])
  );

  // RTC register contents as seen through the port interface.
  function automatic logic [7:0] dato_tabla(input logic [7:0] a);
    case (a)
      8'h21:   return 8'h45;
      8'h22:   return 8'h30;
      8'h23:   return 8'h12;
      8'h24:   return 8'h17;
      8'h25:   return 8'h05;
      8'h26:   return 8'h16;
      default: return 8'h00;
    endcase
  endfunction

  // RTC port-interface model: fin rises retardo cycles after the 0x0E strobe
  // and stays high for 3 cycles; never rises while mudo is set.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rtc
    int         espera = 0;
    int         alto = 0;
    logic [7:0] dir_m = 8'h00;

    always @(posedge clk) begin
      if (wstb[gi] && pid[gi] == 8'h00) dir_m <= opt[gi];
      if (wstb[gi] && pid[gi] == 8'h0E && !mudo[gi]) begin
        espera <= retardo[gi];
        alto   <= 0;
      end else if (espera > 1) begin
        espera <= espera - 1;
      end else if (espera == 1) begin
        espera <= 0;
        alto   <= 3;
      end else if (alto > 0) begin
        alto <= alto - 1;
      end
    end

    assign fin[gi]  = (alto != 0);
    assign drtc[gi] = dato_tabla(dir_m);
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    int          tipo;    // 0 strobe, 1 commit, 2 timeout
    logic [7:0]  puerto;
    logic [7:0]  dato;
    logic [47:0] banco;
    int          delta;
  } esperado_t;

  esperado_t cola[$];

  localparam logic [47:0] BANCO_CERO  = 48'h0;
  localparam logic [47:0] BANCO_LEIDO = 48'h45_30_12_17_05_16;

  logic [47:0] banco_dut;
  assign banco_dut = {bk[0][0], bk[0][1], bk[0][2], bk[0][3], bk[0][4], bk[0][5]};

  task automatic comprobar(input string nombre, input logic [63:0] actual,
                           input logic [63:0] requerido);
    checks++;
    if (actual !== requerido) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nombre, actual, requerido, ciclo);
    end
  endtask

  task automatic push(input int tipo, input logic [7:0] p, input logic [7:0] d,
                      input logic [47:0] b, input int delta);
    esperado_t e;
    e.tipo = tipo; e.puerto = p; e.dato = d; e.banco = b; e.delta = delta;
    cola.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    esperado_t e;
    if (!reset) begin
      comprobar("read_strobe", rstb[0], 1'b0);
      if (wstb[0]) begin
        $display("cycle %0d strobe port_id=%02h out_port=%02h", ciclo, pid[0], opt[0]);
        comprobar("expected_strobe_queued", cola.size() > 0, 1'b1);
        if (cola.size() > 0) begin
          e = cola.pop_front();
          comprobar("strobe_kind", e.tipo, 0);
          comprobar("port_id", pid[0], e.puerto);
          comprobar("out_port", opt[0], e.dato);
          comprobar("bank_stable", banco_dut, e.banco);
        end
        if (pid[0] == 8'h0E) ultimo_0e = ciclo;
      end else begin
        comprobar("port_id_idle", pid[0], 8'hFF);
      end
      if (act[0]) begin
        $display("cycle %0d commit bank=%012h", ciclo, banco_dut);
        comprobar("expected_commit_queued", cola.size() > 0, 1'b1);
        if (cola.size() > 0) begin
          e = cola.pop_front();
          comprobar("commit_kind", e.tipo, 1);
          comprobar("bank_commit", banco_dut, e.banco);
        end
      end
      if (err[0]) begin
        $display("cycle %0d error_timeout, %0d cycles after 0E", ciclo, ciclo - ultimo_0e);
        comprobar("expected_timeout_queued", cola.size() > 0, 1'b1);
        if (cola.size() > 0) begin
          e = cola.pop_front();
          comprobar("timeout_kind", e.tipo, 2);
          comprobar("timeout_delay", ciclo - ultimo_0e, e.delta);
          comprobar("bank_after_timeout", banco_dut, e.banco);
          comprobar("idle_on_timeout", ocu[0], 1'b0);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic pulso(input logic ini, input logic esc, input logic [7:0] a,
                       input logic [7:0] d);
    @(posedge clk);
    #1;
    iniciar = ini; escribir = esc; addr_esc = a; dato_esc = d;
    @(posedge clk);
    #1;
    iniciar = 1'b0; escribir = 1'b0;
  endtask

  task automatic esperar_cola(input int max);
    int n;
    n = 0;
    while (cola.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    comprobar("queue_drained", cola.size(), 0);
  endtask

  task automatic comprobar_reset(input string etiqueta);
    $display("reset check: %s", etiqueta);
    comprobar({etiqueta, "_port_id"}, pid[0], 8'hFF);
    comprobar({etiqueta, "_out_port"}, opt[0], 8'h00);
    comprobar({etiqueta, "_write_strobe"}, wstb[0], 1'b0);
    comprobar({etiqueta, "_read_strobe"}, rstb[0], 1'b0);
    comprobar({etiqueta, "_bank"}, banco_dut, BANCO_CERO);
    comprobar({etiqueta, "_actualizado"}, act[0], 1'b0);
    comprobar({etiqueta, "_ocupado"}, ocu[0], 1'b0);
    comprobar({etiqueta, "_error_timeout"}, err[0], 1'b0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : estimulo
    int   n;
    logic visto;
    reset = 1'b1; iniciar = 1'b0; escribir = 1'b0; addr_esc = 8'h00; dato_esc = 8'h00;
    mudo[0] = 1'b0; mudo[1] = 1'b0; retardo[0] = 20; retardo[1] = 65;
    repeat (3) @(negedge clk);
    comprobar_reset("initial");
    reset = 1'b0;

    // Periodic instance: first sweep is slow enough to span two period ticks.
    n = 0;
    while (!act[1] && n < 1000) begin @(negedge clk); n++; end
    comprobar("auto_sweep_1_commit", act[1], 1'b1);
    comprobar("auto_sweep_1_bank",
              {bk[1][0], bk[1][1], bk[1][2], bk[1][3], bk[1][4], bk[1][5]}, BANCO_LEIDO);
    $display("cycle %0d auto sweep 1 committed", ciclo);
    retardo[1] = 2;
    n = 0;
    while (!ocu[1] && n < 3) begin @(negedge clk); n++; end
    comprobar("auto_sweep_back_to_back", ocu[1], 1'b1);
    n = 0;
    while (!act[1] && n < 200) begin @(negedge clk); n++; end
    comprobar("auto_sweep_2_commit", act[1], 1'b1);
    $display("cycle %0d auto sweep 2 committed", ciclo);
    visto = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (ocu[1]) visto = 1'b1;
    end
    comprobar("no_third_sweep", visto, 1'b0);

    // Full sweep on iniciar.
    for (int i = 0; i < 6; i++) begin
      push(0, 8'h00, 8'h21 + 8'(i), BANCO_CERO, 0);
      push(0, 8'h0E, 8'h01, BANCO_CERO, 0);
    end
    push(1, 8'h00, 8'h00, BANCO_LEIDO, 0);
    pulso(1'b1, 1'b0, 8'h00, 8'h00);
    esperar_cola(400);
    comprobar("idle_after_commit", ocu[0], 1'b0);
    comprobar("bank_after_sweep", banco_dut, BANCO_LEIDO);

    // Single register write.
    push(0, 8'h00, 8'h23, BANCO_LEIDO, 0);
    push(0, 8'h01, 8'h09, BANCO_LEIDO, 0);
    push(0, 8'h0E, 8'h00, BANCO_LEIDO, 0);
    pulso(1'b0, 1'b1, 8'h23, 8'h09);
    esperar_cola(100);
    n = 0;
    while (ocu[0] && n < 100) begin @(negedge clk); n++; end
    comprobar("write_releases_busy", ocu[0], 1'b0);
    comprobar("fin_low_when_idle", fin[0], 1'b0);

    // escribir and iniciar together: write only, no sweep afterwards.
    push(0, 8'h00, 8'h24, BANCO_LEIDO, 0);
    push(0, 8'h01, 8'h11, BANCO_LEIDO, 0);
    push(0, 8'h0E, 8'h00, BANCO_LEIDO, 0);
    pulso(1'b1, 1'b1, 8'h24, 8'h11);
    esperar_cola(100);
    repeat (300) @(negedge clk);
    comprobar("idle_after_simultaneous", ocu[0], 1'b0);

    // Silent RTC: timeout.
    mudo[0] = 1'b1;
    push(0, 8'h00, 8'h21, BANCO_LEIDO, 0);
    push(0, 8'h0E, 8'h01, BANCO_LEIDO, 0);
    push(2, 8'h00, 8'h00, BANCO_LEIDO, 1024);
    pulso(1'b1, 1'b0, 8'h00, 8'h00);
    esperar_cola(1200);
    @(negedge clk);
    comprobar("idle_after_timeout", ocu[0], 1'b0);
    comprobar("bank_kept_after_timeout", banco_dut, BANCO_LEIDO);
    mudo[0] = 1'b0;

    // Reset while waiting for fin on the 4th register.
    for (int i = 0; i < 4; i++) begin
      push(0, 8'h00, 8'h21 + 8'(i), BANCO_LEIDO, 0);
      push(0, 8'h0E, 8'h01, BANCO_LEIDO, 0);
    end
    pulso(1'b1, 1'b0, 8'h00, 8'h00);
    esperar_cola(200);
    repeat (5) @(negedge clk);
    comprobar("busy_before_abort", ocu[0], 1'b1);
    #2;
    reset = 1'b1;
    #1;
    comprobar_reset("async_abort");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    comprobar("queue_empty_after_abort", cola.size(), 0);
    comprobar("bank_zero_after_abort", banco_dut, BANCO_CERO);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
